// File: rtl/adc_axi_read_regbank_if.sv
// AXI4-Lite read-channel signal bundle (AR + R) shared by the register-bank slave and its master.
interface adc_axi_read_regbank_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/adc_axi_read_regbank.sv
// AXI4-Lite read slave for the ADC status/config register bank: one-cycle latency, full-rate
// back-to-back reads, SLVERR on bad addresses, clear-on-read sticky registers and read strobes.
module adc_axi_read_regbank #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] COR_MASK   = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    adc_axi_read_regbank_if.slave    axi,
    input  logic [32*NUM_REGS-1:0]   reg_in,
    input  logic [32*NUM_REGS-1:0]   sticky_set,
    output logic [NUM_REGS-1:0]      rd_pulse,
    output logic [15:0]              rd_err_cnt
);
    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [IDX_W-1:0]    idx_p0;
    logic [31:0]         idx32_p0;
    logic                addr_ok_p0;
    logic                hs_p0;
    logic [31:0]         word_p0;
    logic [NUM_REGS-1:0] sel_p0;
    logic [31:0]         sticky_q [NUM_REGS];

    logic                vld_p1;
    logic [31:0]         rdata_p1;
    logic [1:0]          rresp_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Address stage: decode and data selection on the handshake cycle
    assign axi.ARREADY = !ARESET && (!vld_p1 || axi.RREADY);
    assign hs_p0       = axi.ARVALID && axi.ARREADY;
    assign idx_p0      = axi.ARADDR[ADDR_WIDTH-1:2];
    assign idx32_p0    = 32'(idx_p0);
    assign addr_ok_p0  = (idx32_p0 < 32'(NUM_REGS)) && (axi.ARADDR[1:0] == 2'b00);

    always_comb begin
        word_p0 = '0;
        sel_p0  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ok_p0 && (idx32_p0 == 32'(i))) begin
                sel_p0[i] = 1'b1;
                // Including this cycle's events means a set coincident with the clear is reported
                word_p0 = COR_MASK[i] ? (sticky_q[i] | sticky_set[32*i +: 32])
                                      : reg_in[32*i +: 32];
            end
        end
    end

    // Sticky latches: a read reloads with the same-cycle events so none are lost
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ARESET || !COR_MASK[i]) begin
                sticky_q[i] <= '0;
            end else if (hs_p0 && sel_p0[i]) begin
                sticky_q[i] <= sticky_set[32*i +: 32];
            end else begin
                sticky_q[i] <= sticky_q[i] | sticky_set[32*i +: 32];
            end
        end
    end

    // Response stage: held until the master accepts it
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            vld_p1     <= 1'b0;
            rdata_p1   <= '0;
            rresp_p1   <= RESP_OKAY;
            rd_pulse   <= '0;
            rd_err_cnt <= '0;
        end else begin
            rd_pulse <= hs_p0 ? sel_p0 : '0;
            if (hs_p0) begin
                vld_p1   <= 1'b1;
                rdata_p1 <= word_p0;
                rresp_p1 <= addr_ok_p0 ? RESP_OKAY : RESP_SLVERR;
                if (!addr_ok_p0) begin
                    rd_err_cnt <= sat_inc16(rd_err_cnt);
                end
            end else if (vld_p1 && axi.RREADY) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign axi.RVALID = vld_p1;
    assign axi.RDATA  = rdata_p1;
    assign axi.RRESP  = rresp_p1;

    // Live words of sticky registers and event bits of live registers are never consumed
    logic unused_inputs;
    assign unused_inputs = ^{reg_in, sticky_set};
endmodule

// File: tb/tb_adc_axi_read_regbank.sv
// Scoreboard bench for adc_axi_read_regbank with NUM_REGS=8 and register 4 clear-on-read.
module tb_adc_axi_read_regbank;
    localparam int            AW  = 8;
    localparam int            NR  = 8;
    localparam logic [NR-1:0] COR = 8'h10;

    typedef struct {
        logic [31:0]   data;
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
    } exp_t;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [32*NR-1:0]  reg_in;
    logic [32*NR-1:0]  sticky_set;
    logic [NR-1:0]     rd_pulse;
    logic [15:0]       rd_err_cnt;

    adc_axi_read_regbank_if #(.ADDR_WIDTH(AW)) axi();

    adc_axi_read_regbank #(
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR),
        .COR_MASK  (COR)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .axi       (axi),
        .reg_in    (reg_in),
        .sticky_set(sticky_set),
        .rd_pulse  (rd_pulse),
        .rd_err_cnt(rd_err_cnt)
    );

    always #5 ACLK = ~ACLK;

    exp_t          issue_q[$];
    exp_t          resp_q[$];
    int            n_total = 0;
    int            n_bad = 0;
    int            n_resp = 0;
    int            cyc = 0;
    logic [NR-1:0] pulse_exp = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    always @(posedge ACLK) cyc++;

    // Monitor: strobe check, response pop, and handshake capture into the response queue
    always @(negedge ACLK) begin
        exp_t e;
        check_val("rd_pulse", {24'b0, rd_pulse}, {24'b0, pulse_exp});
        if (axi.RVALID && axi.RREADY) begin
            if (resp_q.size() == 0) begin
                check_val("unexpected_resp", {31'b0, axi.RVALID}, 32'd0);
            end else begin
                e = resp_q.pop_front();
                check_val("rdata", axi.RDATA, e.data);
                check_val("rresp", {30'b0, axi.RRESP}, {30'b0, e.resp});
                n_resp++;
            end
        end
        if (axi.ARVALID && axi.ARREADY && issue_q.size() > 0) begin
            e = issue_q.pop_front();
            resp_q.push_back(e);
            pulse_exp = e.pulse;
        end else begin
            pulse_exp = '0;
        end
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue(input logic [7:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int reg_idx);
        exp_t e;
        int   k = 0;
        e.data  = data;
        e.resp  = resp;
        e.pulse = '0;
        if (reg_idx >= 0) e.pulse[reg_idx] = 1'b1;
        issue_q.push_back(e);
        axi.ARADDR  = addr;
        axi.ARVALID = 1'b1;
        @(negedge ACLK);
        while (!axi.ARREADY && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        if (!axi.ARREADY) check_val("ar_timeout", {31'b0, axi.ARREADY}, 32'd1);
        tick();
        axi.ARVALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        int t0;
        int r0;
        axi.ARADDR  = '0;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;
        reg_in      = '0;
        sticky_set  = '0;

        // Reset and idle
        repeat (3) begin
            @(negedge ACLK);
            check_val("rst_arready", {31'b0, axi.ARREADY}, 32'd0);
            check_val("rst_rvalid", {31'b0, axi.RVALID}, 32'd0);
            check_val("rst_errcnt", {16'b0, rd_err_cnt}, 32'd0);
        end
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        check_val("arready_after_rst", {31'b0, axi.ARREADY}, 32'd1);
        tick();

        // Single read, address changed after handshake, response held with RREADY low
        reg_in[64 +: 32] = 32'hA5A5_0002;
        issue(8'h08, 32'hA5A5_0002, 2'b00, 2);
        axi.ARADDR = 8'h00;
        reg_in[64 +: 32] = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge ACLK);
            check_val("hold_rvalid", {31'b0, axi.RVALID}, 32'd1);
            check_val("hold_rdata", axi.RDATA, 32'hA5A5_0002);
            check_val("hold_rresp", {30'b0, axi.RRESP}, 32'd0);
            check_val("hold_arready", {31'b0, axi.ARREADY}, 32'd0);
        end
        tick();
        axi.RREADY = 1'b1;
        tick();
        tick();

        // Back-to-back reads
        for (int a = 0; a < 4; a++) reg_in[32*a +: 32] = 32'h1000_0000 + 32'(a);
        t0 = cyc;
        r0 = n_resp;
        for (int a = 0; a < 4; a++) issue(8'(a * 4), 32'h1000_0000 + 32'(a), 2'b00, a);
        check_val("b2b_cycles", 32'(cyc - t0), 32'd4);
        tick();
        check_val("b2b_resp_count", 32'(n_resp - r0), 32'd4);
        tick();

        // Bad addresses
        issue(8'h02, 32'h0, 2'b10, -1);
        issue(8'h20, 32'h0, 2'b10, -1);
        tick();
        check_val("err_cnt", {16'b0, rd_err_cnt}, 32'd2);

        // Clear-on-read register 4
        sticky_set[128] = 1'b1;
        tick();
        sticky_set = '0;
        issue(8'h10, 32'h1, 2'b00, 4);
        issue(8'h10, 32'h0, 2'b00, 4);
        sticky_set[131] = 1'b1;
        issue(8'h10, 32'h8, 2'b00, 4);
        sticky_set = '0;
        issue(8'h10, 32'h8, 2'b00, 4);
        issue(8'h10, 32'h0, 2'b00, 4);
        tick();

        // Reset while a response is pending
        sticky_set[133] = 1'b1;
        tick();
        sticky_set = '0;
        axi.RREADY = 1'b0;
        issue(8'h04, 32'h1000_0001, 2'b00, 1);
        ARESET = 1'b1;
        sticky_set[134] = 1'b1;
        @(negedge ACLK);
        tick();
        resp_q.delete();
        sticky_set = '0;
        check_val("rst_drops_rvalid", {31'b0, axi.RVALID}, 32'd0);
        ARESET = 1'b0;
        axi.RREADY = 1'b1;
        repeat (3) tick();
        issue(8'h10, 32'h0, 2'b00, 4);
        tick();
        tick();

        check_val("resp_q_empty", 32'(resp_q.size()), 32'd0);
        check_val("issue_q_empty", 32'(issue_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_axi_read_regbank.md
Name: adc_axi_read_regbank

Overview:
- Parametrised AXI4-Lite read-channel slave serving a bank of NUM_REGS 32-bit registers for ADC capture blocks.
- Successor to the fixed three-register read FSM. Adds:
  - address capture at handshake
  - full-rate back-to-back reads
  - SLVERR for bad addresses
  - per-register clear-on-read sticky bits
  - read strobes
  - error counter
- Sits between the AXI interconnect and the ADC input core's status/config registers. The write path is a separate block.

Parameters:
- ADDR_WIDTH, 8, width of ARADDR; byte address, word index = ARADDR[ADDR_WIDTH-1:2].
- NUM_REGS, 8, number of mapped 32-bit registers (1..2^(ADDR_WIDTH-2)).
- COR_MASK, 0, NUM_REGS-bit vector; bit i=1 makes register i a clear-on-read sticky register.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RDATA  out  32  read data.
- RRESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  master ready for data.
- reg_in  in  32*NUM_REGS  live values; word i at [32*i+31:32*i], used where COR_MASK[i]=0.
- sticky_set  in  32*NUM_REGS  event bits; ORed into sticky latch i where COR_MASK[i]=1.
- rd_pulse  out  NUM_REGS  one-cycle strobe per successful read of register i.
- rd_err_cnt  out  16  saturating count of SLVERR responses.

Behaviour:
- Interface: one clock, ACLK; reset ARESET is synchronous and active-high.
- Reset values while ARESET=1 (all sampled on the ACLK edge):
  - ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00
  - rd_pulse=0, rd_err_cnt=0
  - all sticky latches=0
- Reset mid-transaction: the pending response is discarded and no RVALID is issued afterwards. sticky_set in the reset cycle is lost.
- ARREADY = !ARESET && (!RVALID || RREADY). Combinational from registered state.
- Handshake: an AR handshake occurs when ARVALID && ARREADY at a rising edge. Address and data are captured on that edge; ARADDR is not used afterwards.
- Latency: RVALID rises the cycle after the handshake, so read latency is 1 cycle.
- RVALID/RDATA/RRESP hold stable until RVALID && RREADY.
- Throughput: if RREADY=1 and ARVALID=1 every cycle, one read completes per cycle with no bubbles.
- Decode:
  - idx = ARADDR[ADDR_WIDTH-1:2].
  - Valid iff idx < NUM_REGS and ARADDR[1:0]==0.
  - Invalid: RDATA=0, RRESP=SLVERR, no rd_pulse, no sticky clear. rd_err_cnt increments and saturates at 16'hFFFF.
- Data for a valid read:
  - COR_MASK[idx]=0: RDATA = reg_in word idx, sampled at the handshake edge.
  - COR_MASK[idx]=1: RDATA = latch[idx] | sticky_set word idx at the handshake edge; that latch is then loaded with sticky_set word idx of the same cycle. Simultaneous set and clear: the new event is both reported and retained, so no event is lost.
- Sticky latches with no read: latch <= latch | sticky_set every cycle.
- rd_pulse[idx]: high for exactly one cycle, the cycle RVALID rises for that read (registered). Valid reads only.
- Address wrap: bits above ADDR_WIDTH are not present; there is no aliasing beyond idx decode.
- Protocol: AR accepted while RVALID=1 && RREADY=0 is impossible because ARREADY=0. No reordering.
- Implementation state: response register (RVALID) plus per-register sticky latches, error counter, pulse register.

Test Plan:
- Reset/idle: assert ARESET 3 cycles, then release -> during reset ARREADY=0, RVALID=0, rd_err_cnt=0. First cycle after release: ARREADY=1.
- Single read with latency and address capture:
  - Stimulus: reg_in word 2 = 32'hA5A5_0002; read ARADDR=8'h08; change ARADDR to 8'h00 right after the handshake; hold RREADY=0 for 3 cycles.
  - Response: RVALID rises 1 cycle after the handshake with RDATA=32'hA5A5_0002, RRESP=00, held stable 3 cycles; ARREADY=0 meanwhile; rd_pulse[2] pulses once.
- Back-to-back: RREADY=1, ARVALID=1 for addresses 0x00, 0x04, 0x08, 0x0C on consecutive cycles -> 4 responses on 4 consecutive cycles, in order, ARREADY continuously 1.
- Bad addresses: read 0x02 (misaligned), then 0x20 with NUM_REGS=8 -> both give RRESP=2'b10, RDATA=0, no rd_pulse; rd_err_cnt=2.
- Clear-on-read (COR_MASK=8'h10):
  - Pulse sticky_set word 4 bit 0; read 0x10 -> RDATA=1. Read again -> RDATA=0.
  - Assert bit 3 in the handshake cycle of a read -> that read returns bit 3, and the next read returns bit 3 again.
- Reset mid-transaction: handshake, then ARESET=1 while RVALID=1 && RREADY=0 -> RVALID=0 the next cycle; after release no stale response appears, and sticky latches read 0.
